// File: rtl/cu_eeprom_page_seq.sv
// SPI serial-EEPROM page-write sequencer for fixed-size logger records.
// Define CU_EEPROM_STATUS_POLL_EN to replace the tWC timer with RDSR/WIP polling.
module cu_eeprom_page_seq #(
  parameter int REC_BYTES  = 6,
  parameter int PAGE_BYTES = 64,
  parameter int ADDR_W     = 16,
  parameter int MEM_BYTES  = 32768,
  parameter int TWC_CYC    = 250000,
  parameter int WRAP       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start_pulse,
  input  logic                         spi_busy,
  input  logic [7:0]                   rx_byte,
  output logic                         load_data,
  output logic                         nCS,
  output logic [1:0]                   tx_sel,
  output logic [7:0]                   cmd_byte,
  output logic [$clog2(REC_BYTES)-1:0] sel_data,
  output logic [ADDR_W-1:0]            addr,
  output logic                         page_done,
  output logic                         block_done,
  output logic                         overrun,
  output logic                         busy
);

  localparam int SEL_W = $clog2(REC_BYTES);
  localparam int PG_W  = $clog2(PAGE_BYTES);
  localparam int CNT_W = $clog2(TWC_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, WREN, WREN_GAP, WR_CMD, WR_AH, WR_AL,
    DATA, OPEN_WAIT, CLOSE, TWC, FULL
  } state_t;

  state_t             state_q, state_d;
  logic               spi_busy_q, spi_busy_d;
  logic               sent_q, sent_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, full_d;
  logic               pend_q, pend_d;
  logic               load_data_q, load_data_d;
  logic               nCS_q, nCS_d;
  logic [1:0]         tx_sel_q, tx_sel_d;
  logic [7:0]         cmd_byte_q, cmd_byte_d;
  logic [SEL_W-1:0]   sel_data_q, sel_data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               page_done_q, page_done_d;
  logic               block_done_q, block_done_d;
  logic               overrun_q, overrun_d;
  logic               busy_q, busy_d;

`ifdef CU_EEPROM_STATUS_POLL_EN
  localparam logic [1:0] PH_RDSR  = 2'd0;
  localparam logic [1:0] PH_DUMMY = 2'd1;
  localparam logic [1:0] PH_GAP   = 2'd2;
  logic [1:0] ph_q, ph_d;
  logic       wip_q, wip_d;
  logic       unused_rx;
  assign unused_rx = ^rx_byte[7:1];
`else
  logic       unused_rx;
  assign unused_rx = ^rx_byte;
`endif

  logic [ADDR_W:0]  addr_inc;
  logic             full_now;
  logic             boundary;
  logic [SEL_W-1:0] sel_inc;
  logic             rec_end;
  logic             byte_done;
  logic             pend_now;
  logic             fin;

  assign addr_inc  = {1'b0, addr_q} + (ADDR_W+1)'(1);
  assign full_now  = addr_inc == (ADDR_W+1)'(MEM_BYTES);
  assign boundary  = addr_inc[PG_W-1:0] == '0;
  assign sel_inc   = sel_data_q + SEL_W'(1);
  assign rec_end   = sel_data_q == SEL_W'(REC_BYTES - 1);
  assign byte_done = sent_q & spi_busy_q & ~spi_busy;
  assign pend_now  = pend_q | (start_pulse & (sel_data_q == '0));

  always_comb begin
    state_d      = state_q;
    spi_busy_d   = spi_busy;
    sent_d       = sent_q;
    cnt_d        = cnt_q;
    full_d       = full_q;
    pend_d       = pend_q;
    load_data_d  = 1'b0;
    nCS_d        = nCS_q;
    tx_sel_d     = tx_sel_q;
    cmd_byte_d   = cmd_byte_q;
    sel_data_d   = sel_data_q;
    addr_d       = addr_q;
    page_done_d  = 1'b0;
    block_done_d = 1'b0;
    overrun_d    = overrun_q;
    fin          = 1'b0;
`ifdef CU_EEPROM_STATUS_POLL_EN
    ph_d         = ph_q;
    wip_d        = wip_q;
`endif

    // Only a record-complete idle point accepts a record; a pulse
    // during a clean tWC is held and replayed when the page reopens.
    if (start_pulse &&
        !(state_q inside {IDLE, OPEN_WAIT}) &&
        !(state_q == TWC && sel_data_q == '0))
      overrun_d = 1'b1;

    unique case (state_q)
      IDLE: if (start_pulse) state_d = WREN;
      WREN: begin
        if (!sent_q) begin
          load_data_d = 1'b1;
          sent_d      = 1'b1;
        end else if (byte_done) begin
          sent_d  = 1'b0;
          cnt_d   = '0;
          state_d = WREN_GAP;
        end
      end
      WREN_GAP: begin
        if (cnt_q == CNT_W'(1)) state_d = WR_CMD;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      WR_CMD, WR_AH, WR_AL: begin
        if (!sent_q) begin
          load_data_d = 1'b1;
          sent_d      = 1'b1;
        end else if (byte_done) begin
          sent_d = 1'b0;
          unique case (state_q)
            WR_CMD:  state_d = WR_AH;
            WR_AH:   state_d = WR_AL;
            default: state_d = DATA;
          endcase
        end
      end
      DATA: begin
        if (!sent_q) begin
          load_data_d = 1'b1;
          sent_d      = 1'b1;
        end else if (byte_done) begin
          sent_d     = 1'b0;
          sel_data_d = rec_end ? '0 : sel_inc;
          addr_d     = (full_now && WRAP != 0) ? '0
                                               : addr_inc[ADDR_W-1:0];
          if (boundary) begin
            state_d      = CLOSE;
            page_done_d  = 1'b1;
            block_done_d = full_now;
            full_d       = full_q | (full_now & (WRAP == 0));
          end else if (rec_end) begin
            state_d = OPEN_WAIT;
          end
        end
      end
      OPEN_WAIT: if (start_pulse) state_d = DATA;
      CLOSE: begin
        state_d = TWC;
        cnt_d   = '0;
        pend_d  = 1'b0;
`ifdef CU_EEPROM_STATUS_POLL_EN
        ph_d    = PH_RDSR;
`endif
      end
      TWC: begin
        pend_d = pend_now;
`ifdef CU_EEPROM_STATUS_POLL_EN
        unique case (ph_q)
          PH_RDSR, PH_DUMMY: begin
            if (!sent_q) begin
              load_data_d = 1'b1;
              sent_d      = 1'b1;
            end else if (byte_done) begin
              sent_d = 1'b0;
              if (ph_q == PH_RDSR) begin
                ph_d = PH_DUMMY;
              end else begin
                wip_d = rx_byte[0];
                cnt_d = '0;
                ph_d  = PH_GAP;
              end
            end
          end
          default: begin
            if (cnt_q == CNT_W'(1)) begin
              if (wip_q) ph_d = PH_RDSR;
              else fin = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        endcase
`else
        if (cnt_q == CNT_W'(TWC_CYC - 1)) fin = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
`endif
        if (fin) begin
          pend_d = 1'b0;
          if (full_q) state_d = FULL;
          else if (sel_data_q != '0 || pend_now) state_d = WREN;
          else state_d = IDLE;
        end
      end
      FULL: state_d = FULL;
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d inside {IDLE, OPEN_WAIT});
    unique case (state_d)
      WREN: begin
        nCS_d      = 1'b0;
        tx_sel_d   = 2'd0;
        cmd_byte_d = 8'h06;
      end
      WR_CMD: begin
        nCS_d      = 1'b0;
        tx_sel_d   = 2'd0;
        cmd_byte_d = 8'h02;
      end
      WR_AH: begin
        nCS_d    = 1'b0;
        tx_sel_d = 2'd1;
      end
      WR_AL: begin
        nCS_d    = 1'b0;
        tx_sel_d = 2'd2;
      end
      DATA, OPEN_WAIT: begin
        nCS_d    = 1'b0;
        tx_sel_d = 2'd3;
      end
`ifdef CU_EEPROM_STATUS_POLL_EN
      TWC: begin
        nCS_d      = ph_d == PH_GAP;
        tx_sel_d   = 2'd0;
        cmd_byte_d = 8'h05;
      end
`endif
      default: nCS_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      spi_busy_q   <= 1'b0;
      sent_q       <= 1'b0;
      cnt_q        <= '0;
      full_q       <= 1'b0;
      pend_q       <= 1'b0;
      load_data_q  <= 1'b0;
      nCS_q        <= 1'b1;
      tx_sel_q     <= 2'd0;
      cmd_byte_q   <= 8'h00;
      sel_data_q   <= '0;
      addr_q       <= '0;
      page_done_q  <= 1'b0;
      block_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef CU_EEPROM_STATUS_POLL_EN
      ph_q         <= PH_RDSR;
      wip_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      spi_busy_q   <= spi_busy_d;
      sent_q       <= sent_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      pend_q       <= pend_d;
      load_data_q  <= load_data_d;
      nCS_q        <= nCS_d;
      tx_sel_q     <= tx_sel_d;
      cmd_byte_q   <= cmd_byte_d;
      sel_data_q   <= sel_data_d;
      addr_q       <= addr_d;
      page_done_q  <= page_done_d;
      block_done_q <= block_done_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
`ifdef CU_EEPROM_STATUS_POLL_EN
      ph_q         <= ph_d;
      wip_q        <= wip_d;
`endif
    end
  end

  assign load_data  = load_data_q;
  assign nCS        = nCS_q;
  assign tx_sel     = tx_sel_q;
  assign cmd_byte   = cmd_byte_q;
  assign sel_data   = sel_data_q;
  assign addr       = addr_q;
  assign page_done  = page_done_q;
  assign block_done = block_done_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cu_eeprom_page_seq.sv
// Scoreboard bench: record-level model predicts the SPI byte stream
// and page/block events; a monitor pops and compares on every load_data.
module tb_cu_eeprom_page_seq;

  localparam int REC  = 6;
  localparam int PAGE = 64;
  localparam int AW   = 16;
  localparam int MEM  = 128;
  localparam int TWC  = 20;
  localparam int LIM  = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_pulse;
  logic          spi_busy;
  logic [7:0]    rx_byte;
  logic          load_data;
  logic          nCS;
  logic [1:0]    tx_sel;
  logic [7:0]    cmd_byte;
  logic [2:0]    sel_data;
  logic [AW-1:0] addr;
  logic          page_done;
  logic          block_done;
  logic          overrun;
  logic          busy;

  cu_eeprom_page_seq #(
    .REC_BYTES(REC), .PAGE_BYTES(PAGE), .ADDR_W(AW),
    .MEM_BYTES(MEM), .TWC_CYC(TWC), .WRAP(0)
  ) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse),
    .spi_busy(spi_busy), .rx_byte(rx_byte),
    .load_data(load_data), .nCS(nCS), .tx_sel(tx_sel),
    .cmd_byte(cmd_byte), .sel_data(sel_data), .addr(addr),
    .page_done(page_done), .block_done(block_done),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         page;
    bit         blk;
    logic [7:0] val;
    int         gap;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rec_buf [REC];
  int         errors = 0;
  int         checks = 0;
  int         hcnt;
  int         m_addr;
  bit         m_open;
  bit         m_first;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] v, input int g);
    exp_t e;
    e.page = 1'b0;
    e.blk  = 1'b0;
    e.val  = v;
    e.gap  = g;
    sb.push_back(e);
  endtask

  // One record: header whenever no page is open, data bytes at
  // consecutive addresses, page close at every PAGE-aligned address.
  task automatic model_record();
    exp_t e;
    for (int j = 0; j < REC; j++) begin
      if (m_addr >= MEM) break;
      if (!m_open) begin
        push_byte(8'h06, m_first ? 1 : TWC);
        m_first = 1'b0;
        push_byte(8'h02, 2);
        push_byte(8'((m_addr >> 8) & 255), 0);
        push_byte(8'(m_addr & 255), 0);
        m_open = 1'b1;
      end
      push_byte(rec_buf[j], 0);
      m_addr++;
      if (m_addr % PAGE == 0) begin
        e.page = 1'b1;
        e.blk  = (m_addr == MEM);
        e.val  = 8'h00;
        e.gap  = 0;
        sb.push_back(e);
        m_open = 1'b0;
      end
    end
  endtask

  task automatic pulse();
    @(negedge clk) start_pulse = 1'b1;
    @(negedge clk) start_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < LIM, 1);
  endtask

  // SPI master stand-in: busy for a few cycles after each load.
  initial begin
    spi_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && load_data) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #1 spi_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        #1 spi_busy = 1'b0;
      end
    end
  end

  initial begin
    exp_t       e;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (load_data) begin
          case (tx_sel)
            2'd0:    b = cmd_byte;
            2'd1:    b = addr[15:8];
            2'd2:    b = addr[7:0];
            default: b = rec_buf[sel_data];
          endcase
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL load: got byte %02h, expected no load", b);
          end else begin
            e = sb.pop_front();
            if (e.page || b !== e.val || nCS !== 1'b0 || spi_busy ||
                (e.gap == 0 ? hcnt != 0 : hcnt < e.gap)) begin
              errors++;
              $display("FAIL load: got byte=%02h nCS=%0b gap=%0d, expected byte=%02h gap=%0d page_evt=%0b",
                       b, nCS, hcnt, e.val, e.gap, e.page);
            end
          end
          hcnt = 0;
        end
        if (page_done || block_done) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL page: got page_done=%0b block_done=%0b, expected none",
                     page_done, block_done);
          end else begin
            e = sb.pop_front();
            if (!e.page || !page_done || block_done !== e.blk ||
                nCS !== 1'b1) begin
              errors++;
              $display("FAIL page: got page=%0b block=%0b nCS=%0b, expected page=%0b block=%0b nCS=1",
                       page_done, block_done, nCS, e.page, e.blk);
            end
          end
        end
      end
      if (nCS) hcnt++;
    end
  end

  initial begin
    int n;
    reset       = 1'b0;
    start_pulse = 1'b0;
    rx_byte     = 8'h00;
    hcnt        = 0;
    m_addr      = 0;
    m_open      = 1'b0;
    m_first     = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst nCS", nCS, 1);
    chk("rst load_data", load_data, 0);
    chk("rst tx_sel", tx_sel, 0);
    chk("rst cmd_byte", cmd_byte, 0);
    chk("rst sel_data", sel_data, 0);
    chk("rst addr", addr, 0);
    chk("rst page_done", page_done, 0);
    chk("rst block_done", block_done, 0);
    chk("rst overrun", overrun, 0);
    chk("rst busy", busy, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    foreach (rec_buf[i]) rec_buf[i] = 8'($urandom);
    model_record();
    pulse();
    n = 0;
    while (!(addr == 5 && tx_sel == 2'd3) && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("reach addr 5", n < LIM, 1);
    #1 reset = 1'b0;
    #1;
    chk("midrst nCS", nCS, 1);
    chk("midrst load_data", load_data, 0);
    chk("midrst tx_sel", tx_sel, 0);
    chk("midrst cmd_byte", cmd_byte, 0);
    chk("midrst sel_data", sel_data, 0);
    chk("midrst addr", addr, 0);
    chk("midrst page_done", page_done, 0);
    chk("midrst block_done", block_done, 0);
    chk("midrst overrun", overrun, 0);
    chk("midrst busy", busy, 0);
    sb.delete();
    m_addr  = 0;
    m_open  = 1'b0;
    m_first = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    for (int r = 1; m_addr < MEM; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      foreach (rec_buf[i]) rec_buf[i] = 8'($urandom);
      model_record();
      pulse();
      if (r == 3) begin
        n = 0;
        while (!(busy && !nCS && tx_sel == 2'd3) && n < LIM) begin
          @(negedge clk);
          n++;
        end
        chk("reach DATA", n < LIM, 1);
        chk("overrun before", overrun, 0);
        start_pulse = 1'b1;
        @(negedge clk) start_pulse = 1'b0;
        chk("overrun set", overrun, 1);
      end
      if (m_addr >= MEM) break;
      wait_idle("record done");
      chk("addr after record", addr, m_addr);
      chk("nCS after record", nCS, m_open ? 0 : 1);
      chk("sel_data after record", sel_data, 0);
      if (r == 1) chk("addr rec1", addr, 6);
      if (r == 11) chk("addr rec11", addr, 66);
    end

    n = 0;
    while (sb.size() != 0 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    chk("drain", n < LIM, 1);
    repeat (TWC + 20) @(negedge clk);
    chk("full busy", busy, 1);
    chk("full nCS", nCS, 1);
    chk("full addr", addr, MEM);
    pulse();
    repeat (10) @(negedge clk);
    pulse();
    repeat (40) @(negedge clk);
    chk("full no traffic", sb.size(), 0);
    chk("overrun sticky", overrun, 1);
    chk("full still", busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
